// File: rtl/pd_power_seq_ctrl.sv
// Power-domain sequencer: isolate -> save -> power off, power on -> restore -> de-isolate.
// Optional retention states are compiled in with `define PD_RETENTION_EN.
module pd_power_seq_ctrl #(
   parameter int unsigned ISO_SETUP_CYC   = 2,
   parameter int unsigned RET_CYC         = 1,
   parameter int unsigned PWR_ACK_TIMEOUT = 255,
   parameter int unsigned CNT_W           = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pwr_down_req,
   input  logic       pwr_up_req,
   input  logic       pwr_ack,
   input  logic       err_clr,
   output logic       iso_en,
   output logic       save,
   output logic       restore,
   output logic       pwr_sw_en,
   output logic       busy,
   output logic [2:0] state_o,
   output logic       err_timeout
);

   typedef enum logic [2:0] {
      StOn         = 3'd0,
      StIsoAssert  = 3'd1,
      StSave       = 3'd2,
      StPwrOffWait = 3'd3,
      StOff        = 3'd4,
      StPwrOnWait  = 3'd5,
      StRestore    = 3'd6,
      StIsoRelease = 3'd7
   } stateT;

   localparam logic [CNT_W-1:0] isoLast     = CNT_W'(ISO_SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] retLast     = CNT_W'(RET_CYC - 1);
   localparam logic [CNT_W-1:0] timeoutLast = CNT_W'(PWR_ACK_TIMEOUT - 1);
   localparam bit               timeoutEn   = (PWR_ACK_TIMEOUT != 0);

`ifdef PD_RETENTION_EN
   localparam stateT afterIso   = StSave;
   localparam stateT afterPwrOn = StRestore;
`else
   localparam stateT afterIso   = StPwrOffWait;
   localparam stateT afterPwrOn = StIsoRelease;
`endif

   stateT            stateQ, stateD;
   logic [CNT_W-1:0] cntQ, cntD;
   logic             ackMeta, ackS;
   logic             timeoutHit;
   logic             isoD, saveD, restoreD, swD, busyD, errD;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ackMeta <= 1'b0;
         ackS    <= 1'b0;
      end else begin
         ackMeta <= pwr_ack;
         ackS    <= ackMeta;
      end
   end

   always_comb begin
      stateD     = stateQ;
      timeoutHit = 1'b0;
      unique case (stateQ)
         StOn:         if (pwr_down_req) stateD = StIsoAssert;
         StIsoAssert:  if (cntQ == isoLast) stateD = afterIso;
         StSave:       if (cntQ == retLast) stateD = StPwrOffWait;
         StPwrOffWait: begin
            if (!ackS) begin
               stateD = StOff;
            end else if (timeoutEn && cntQ == timeoutLast) begin
               stateD     = StOff;
               timeoutHit = 1'b1;
            end
         end
         StOff:        if (pwr_up_req) stateD = StPwrOnWait;
         StPwrOnWait: begin
            if (ackS) begin
               stateD = afterPwrOn;
            end else if (timeoutEn && cntQ == timeoutLast) begin
               // Rail never came good: fall back to OFF, isolation stays on.
               stateD     = StOff;
               timeoutHit = 1'b1;
            end
         end
         StRestore:    if (cntQ == retLast) stateD = StIsoRelease;
         StIsoRelease: if (cntQ == isoLast) stateD = StOn;
         default:      stateD = StOn;
      endcase

      cntD = (stateD != stateQ) ? '0 : cntQ + CNT_W'(1);

      // Outputs are decoded from the next state so they register on the same edge.
      isoD     = (stateD != StOn);
      swD      = !(stateD == StPwrOffWait || stateD == StOff);
      busyD    = !(stateD == StOn || stateD == StOff);
`ifdef PD_RETENTION_EN
      saveD    = (stateD == StSave);
      restoreD = (stateD == StRestore);
`else
      saveD    = 1'b0;
      restoreD = 1'b0;
`endif

      errD = err_timeout;
      if (timeoutHit) begin
         errD = 1'b1;
      end else if (err_clr) begin
         errD = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stateQ      <= StOn;
         cntQ        <= '0;
         iso_en      <= 1'b0;
         save        <= 1'b0;
         restore     <= 1'b0;
         pwr_sw_en   <= 1'b1;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         stateQ      <= stateD;
         cntQ        <= cntD;
         iso_en      <= isoD;
         save        <= saveD;
         restore     <= restoreD;
         pwr_sw_en   <= swD;
         busy        <= busyD;
         err_timeout <= errD;
      end
   end

   assign state_o = stateQ;

endmodule
